// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the Booth multiplier slice.
package booth_pkg;

   // Controller states: load on start, one Booth step per clock, then publish.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } booth_state_t;

   // Default operand width used by the slice.
   localparam int BOOTH_BUS_SIZE_DEF = 4;

   // Step counter must hold the value bus_size itself.
   function automatic int booth_cnt_w(input int bus_size);
      return $clog2(bus_size + 1);
   endfunction

   localparam int BOOTH_CNT_W_DEF = booth_cnt_w(BOOTH_BUS_SIZE_DEF);

endpackage

// File: rtl/booth_multiplier_ctrl_if.sv
// Request/result bundle between a multiply requester and the Booth unit.
interface booth_multiplier_ctrl_if #(
   parameter int bus_size = 4
);
   logic                    start;
   logic [bus_size-1:0]     multiplicand;
   logic [bus_size-1:0]     multiplier;
   logic                    busy;
   logic                    done;
   logic [2*bus_size-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/parameterizable_2_complement.sv
// Conditional one's complementer; cout carries the +1 that completes negation.
module parameterizable_2_complement #(
   parameter int width = 5
) (
   input  logic             enable,
   input  logic [width-1:0] operand,
   output logic [width-1:0] result,
   output logic             cout
);

   assign result = enable ? ~operand : operand;
   assign cout   = enable;

endmodule

// File: rtl/booth_multiplier_ctrl.sv
// Sequential radix-2 Booth signed multiplier: FSM, datapath registers and
// a shared adder fed through the conditional complementer.
module booth_multiplier_ctrl
   import booth_pkg::*;
#(
   parameter int bus_size = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   booth_multiplier_ctrl_if.slave bus
);

   localparam int N     = bus_size;
   localparam int CNT_W = booth_cnt_w(bus_size);

   booth_state_t        state, state_nxt;
   logic [N:0]          a_reg;      // extra bit keeps -M representable for M = -2^(N-1)
   logic [N:0]          m_reg;
   logic [N-1:0]        q_reg;
   logic                q_1;
   logic [CNT_W-1:0]    cnt;
   logic                busy_r;
   logic                done_r;
   logic [2*N-1:0]      product_r;

   logic                neg_en;
   logic                add_en;
   logic [N:0]          m_cond;
   logic                m_cin;
   logic [N:0]          a_nxt;

   // Pair 10 subtracts M, pair 01 adds M; 00/11 leave A alone.
   assign neg_en = q_reg[0] & ~q_1;
   assign add_en = q_reg[0] ^ q_1;

   parameterizable_2_complement #(bus_size + 1) u_comp (
      .enable  (neg_en),
      .operand (m_reg),
      .result  (m_cond),
      .cout    (m_cin)
   );

   // Next-state decode and the pre-shift accumulator value (adder carry-out dropped).
   always_comb begin
      state_nxt = state;
      a_nxt     = a_reg;
      if (add_en)
         a_nxt = a_reg + m_cond + {{N{1'b0}}, m_cin};
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN:  if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and datapath; reset aborts any operation and clears the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         m_reg     <= '0;
         q_reg     <= '0;
         q_1       <= 1'b0;
         cnt       <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= '0;
      end else begin
         state  <= state_nxt;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               // busy stays up through the cycle done is shown, drops after
               busy_r <= bus.start;
               if (bus.start) begin
                  a_reg <= '0;
                  q_reg <= bus.multiplier;
                  q_1   <= 1'b0;
                  m_reg <= {bus.multiplicand[N-1], bus.multiplicand};
                  cnt   <= CNT_W'(N);
               end
            end
            RUN: begin
               // arithmetic shift right of {A,Q,q_1}
               a_reg <= {a_nxt[N], a_nxt[N:1]};
               q_reg <= {a_nxt[0], q_reg[N-1:1]};
               q_1   <= q_reg[0];
               cnt   <= cnt - CNT_W'(1);
            end
            DONE: begin
               product_r <= {a_reg[N-1:0], q_reg};
               done_r    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;

endmodule
